wb_burst_mem_slave: RTL and testbench
=====================================

// Module: wb_burst_mem_slave
// PURPOSE
// Wishbone B4 registered-feedback memory slave that sits directly downstream of the fuzzer bridge master port (wbm_*).
// It services the bridge's EXT_RW_WIDTH bursts and single beats from an internal word-addressed RAM.
// Wait states are programmable; byte-lane selects, linear/wrapping burst addressing and out-of-range error signalling are supported.
// The fuzzer uses it as the reference target for closed-loop master-port checks.
// PARAMETERS
// ADDR_WIDTH   32  byte-address width
// DATA_WIDTH   32  data width, multiple of 8; NB = DATA_WIDTH/8 byte lanes
// DEPTH        256 RAM depth in words; power of two
// WAIT_CYCLES  0   extra cycles inserted before every ack/err (0..15)
// PORTS
// clk         in   1           clock, all logic on rising edge
// rst_n       in   1           asynchronous active-low reset
// wbs_cyc_i   in   1           bus cycle valid
// wbs_stb_i   in   1           strobe
// wbs_we_i    in   1           1 = write, 0 = read
// wbs_adr_i   in   ADDR_WIDTH  byte address; word index = adr >> log2(NB)
// wbs_dat_i   in   DATA_WIDTH  write data
// wbs_sel_i   in   NB          byte-lane enables
// wbs_cti_i   in   3           000 classic, 010 incrementing burst, 111 end of burst
// wbs_bte_i   in   2           00 linear, 01 wrap4, 10 wrap8, 11 wrap16
// wbs_dat_o   out  DATA_WIDTH  read data, valid while wbs_ack_o = 1
// wbs_ack_o   out  1           beat acknowledge, one-cycle pulse
// wbs_err_o   out  1           beat error, one-cycle pulse
// beat_cnt_o  out  8           beats acked in current cycle, saturating at 255
// busy_o      out  1           state != S_IDLE
// BEHAVIOUR
// - Reset values: wbs_dat_o = 0, wbs_ack_o = 0, wbs_err_o = 0, beat_cnt_o = 0, busy_o = 0, state S_IDLE, wait counter 0.
// - RAM contents are not reset.
// - S_IDLE:
//   - At an edge with cyc & stb, latch widx = word index of wbs_adr_i, plus we, sel, dat, cti, bte.
//   - Go to S_WAIT if WAIT_CYCLES > 0, else S_ACK.
// - S_WAIT: count WAIT_CYCLES edges, then go to S_ACK.
// - S_ACK: ack (or err) is high for exactly this one cycle, so first-beat latency = 1 + WAIT_CYCLES cycles after the stb sample edge.
// - In range (widx < DEPTH):
//   - Read: wbs_dat_o = RAM[widx], registered on entry to S_ACK.
//   - Write: lanes with sel = 1 update RAM[widx] at the edge leaving S_ACK; sel = 0 lanes are kept.
//   - beat_cnt_o increments.
// - Out of range: wbs_err_o pulses instead of ack; no RAM write; wbs_dat_o holds its previous value.
// - ack and err are never high together.
// - Leaving S_ACK:
//   - If the latched cti = 010, no error, and cyc & stb are still high: next beat uses the internal address, not wbs_adr_i.
//   - Internal address: linear widx+1; wrap-N widx = (widx & ~(N-1)) | ((widx+1) & (N-1)).
//   - Resample we, sel, dat, cti on that edge, then go to S_WAIT/S_ACK.
//   - With WAIT_CYCLES = 0 this gives back-to-back acks.
//   - Otherwise go to S_IDLE; classic beats therefore have at least one idle cycle between acks.
// - Linear increment past DEPTH-1 produces an out-of-range widx, which errs; widx is never truncated to wrap the RAM.
// - Abort: cyc = 0 in S_WAIT or S_ACK forces S_IDLE next edge.
//   - Any ack pending in S_WAIT is dropped; a write pending in S_ACK is not committed.
// - beat_cnt_o clears at the first edge with cyc = 0.
// - stb = 0 with cyc = 1 in S_IDLE is a bus idle; stay in S_IDLE and keep beat_cnt_o.
// - rst_n low at any time forces the reset values immediately; the RAM is left unchanged.
// - An in-flight write not yet at its S_ACK exit edge is lost.
// TESTING
// - Write 8-beat burst at 0x100 (cti 010 x7, then 111), data 0x11..0x88, sel = F:
//   - expect 8 acks, back-to-back at WAIT_CYCLES = 0;
//   - an 8-beat read burst returns 0x11..0x88 in order.
// - Write 0x11111111 to 0x40, then write 0xAABBCCDD with sel = 0010: a read of 0x40 returns 0x1111CC11.
// - Read burst at 0x10C, bte = 01, 4 beats: data from words 0x10C, 0x100, 0x104, 0x108.
// - Read at byte address DEPTH*4: err pulses 1 cycle, ack stays 0; a write to that address leaves RAM unchanged.
// - WAIT_CYCLES = 2, single classic read: ack rises 3 cycles after the stb sample edge and lasts 1 cycle.
// - Abort cases:
//   - Drop cyc after 3 of 8 burst beats: no further ack, beat_cnt_o returns to 0, busy_o = 0.
//   - Pulse rst_n low mid-burst: all outputs are 0 at once.
//   - In both cases the next classic read succeeds.

Source files
------------

// File: rtl/wb_burst_mem_slave.sv
// Wishbone B4 registered-feedback memory slave: word-addressed RAM with programmable
// wait states, byte-lane writes, linear/wrapping incrementing bursts and out-of-range error.
module wb_burst_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [ADDR_WIDTH-1:0]   wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [2:0]              wbs_cti_i,
  input  logic [1:0]              wbs_bte_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic [7:0]              beat_cnt_o,
  output logic                    busy_o
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LNB = $clog2(NB);
  localparam int IW  = ADDR_WIDTH - LNB;
  localparam int MW  = $clog2(DEPTH);
  localparam logic [IW-1:0] DEPTH_W   = IW'(DEPTH);
  localparam logic [3:0]    WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [2:0]    CTI_INCR  = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  localparam state_t BEAT_ENTRY = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;

  state_t state, state_next;

  logic [IW-1:0]         widx, bus_widx, widx_inc, wrap_mask, ack_idx;
  logic                  we_q, ack_we;
  logic [NB-1:0]         sel_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [2:0]            cti_q;
  logic [1:0]            bte_q;
  logic [3:0]            wcnt;
  logic                  in_range, start, burst_go, commit;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign bus_widx = wbs_adr_i[ADDR_WIDTH-1:LNB];
  assign in_range = (widx < DEPTH_W);
  assign start    = (state == S_IDLE) && wbs_cyc_i && wbs_stb_i;
  assign burst_go = (state == S_ACK) && wbs_cyc_i && wbs_stb_i && (cti_q == CTI_INCR) && in_range;
  assign commit   = (state == S_ACK) && wbs_cyc_i && we_q && in_range;

  always_comb begin
    unique case (bte_q)
      2'b01:   wrap_mask = IW'(3);
      2'b10:   wrap_mask = IW'(7);
      2'b11:   wrap_mask = IW'(15);
      default: wrap_mask = '0;
    endcase
  end

  // Linear bursts may run past DEPTH-1; the index is never folded back into the RAM.
  assign widx_inc = (bte_q == 2'b00) ? widx + IW'(1)
                                     : (widx & ~wrap_mask) | ((widx + IW'(1)) & wrap_mask);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start) state_next = BEAT_ENTRY;
      S_WAIT: begin
        if (!wbs_cyc_i)              state_next = S_IDLE;
        else if (wcnt == WAIT_LAST)  state_next = S_ACK;
      end
      S_ACK:   state_next = burst_go ? BEAT_ENTRY : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wbs_ack_o = (state == S_ACK) && in_range;
    wbs_err_o = (state == S_ACK) && !in_range;
    busy_o    = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          wcnt <= '0;
    else if ((state == S_WAIT) && (state_next == S_WAIT)) wcnt <= wcnt + 4'd1;
    else                                                  wcnt <= '0;
  end

  // Address and direction of the beat about to enter S_ACK, for the registered read.
  always_comb begin
    unique case (state)
      S_IDLE:  begin ack_idx = bus_widx; ack_we = wbs_we_i; end
      S_WAIT:  begin ack_idx = widx;     ack_we = we_q;     end
      default: begin ack_idx = widx_inc; ack_we = wbs_we_i; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx       <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
      cti_q      <= '0;
      bte_q      <= '0;
      wbs_dat_o  <= '0;
      beat_cnt_o <= '0;
    end else begin
      if (start) begin
        widx  <= bus_widx;
        we_q  <= wbs_we_i;
        sel_q <= wbs_sel_i;
        dat_q <= wbs_dat_i;
        cti_q <= wbs_cti_i;
        bte_q <= wbs_bte_i;
      end else if (burst_go) begin
        widx  <= widx_inc;
        we_q  <= wbs_we_i;
        sel_q <= wbs_sel_i;
        dat_q <= wbs_dat_i;
        cti_q <= wbs_cti_i;
      end

      if ((state_next == S_ACK) && !ack_we && (ack_idx < DEPTH_W))
        wbs_dat_o <= mem[ack_idx[MW-1:0]];

      if (!wbs_cyc_i)
        beat_cnt_o <= '0;
      else if ((state == S_ACK) && in_range && (beat_cnt_o != 8'hFF))
        beat_cnt_o <= beat_cnt_o + 8'd1;
    end
  end

  // NOTE: the RAM has no reset; contents survive rst_n and start undefined after power-up.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_q[b]) mem[widx[MW-1:0]][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Directed bench for wb_burst_mem_slave: bursts, byte lanes, wrap, errors, wait states, aborts.
module tb_wb_burst_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic [31:0] dat_o, dat2;
  logic        ack, err, busy, ack2, err2, busy2;
  logic [7:0]  bc, bc2;

  int checks = 0;
  int errors = 0;

  logic [31:0] wdata [16];
  logic [31:0] rdata [16];
  logic        berr  [16];

  always #5 clk = ~clk;

  wb_burst_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack), .wbs_err_o(err), .beat_cnt_o(bc), .busy_o(busy)
  );

  wb_burst_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(2)) dut_wait (
    .clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_dat_o(dat2), .wbs_ack_o(ack2), .wbs_err_o(err2), .beat_cnt_o(bc2), .busy_o(busy2)
  );

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) begin
      berr[i] = 1'b0;
    end
  endtask

  // Bus idle between transactions: one edge with cyc low.
  task automatic end_cycle();
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  // Burst (or single classic beat when n == 1) against the zero-wait instance.
  task automatic do_burst(input logic w, input logic [31:0] a, input int n,
                          input logic [1:0] b, input logic [3:0] s, input string name);
    int good = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; bte = b; sel = s; dat = wdata[0];
    cti = (n == 1) ? 3'b000 : 3'b010;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k + 1 < n) begin
        dat = wdata[k+1];
        cti = (k + 1 == n - 1) ? 3'b111 : 3'b010;
      end else begin
        stb = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (ack !== !berr[k] || err !== berr[k]) begin
        errors++;
        $display("FAIL %s beat %0d: ack=%b err=%b, required ack=%b err=%b",
                 name, k, ack, err, !berr[k], berr[k]);
      end
      if (!berr[k]) good++;
      if (!w && !berr[k]) begin
        checks++;
        if (dat_o !== rdata[k]) begin
          errors++;
          $display("FAIL %s data beat %0d: got %h, required %h", name, k, dat_o, rdata[k]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || bc !== 8'(good)) begin
      errors++;
      $display("FAIL %s end: ack=%b err=%b busy=%b beat_cnt=%0d, required 0 0 0 %0d",
               name, ack, err, busy, bc, good);
    end
    end_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
    sel = '0; cti = '0; bte = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dat_o !== '0 || ack !== 1'b0 || err !== 1'b0 || bc !== '0 || busy !== 1'b0 ||
        dat2 !== '0 || ack2 !== 1'b0 || err2 !== 1'b0 || bc2 !== '0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset: dat=%h ack=%b err=%b cnt=%0d busy=%b / wait dut dat=%h ack=%b err=%b cnt=%0d busy=%b, required all 0",
               dat_o, ack, err, bc, busy, dat2, ack2, err2, bc2, busy2);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_burst_linear();
    clear_exp();
    for (int i = 0; i < 8; i++) begin
      wdata[i] = 32'h11 * (i + 1);
      rdata[i] = 32'h11 * (i + 1);
    end
    do_burst(1'b1, 32'h100, 8, 2'b00, 4'hF, "wr_burst8");
    do_burst(1'b0, 32'h100, 8, 2'b00, 4'hF, "rd_burst8");
  endtask

  task automatic test_byte_lanes();
    clear_exp();
    wdata[0] = 32'h1111_1111;
    do_burst(1'b1, 32'h40, 1, 2'b00, 4'hF, "wr_full_0x40");
    wdata[0] = 32'hAABB_CCDD;
    do_burst(1'b1, 32'h40, 1, 2'b00, 4'b0010, "wr_lane1_0x40");
    rdata[0] = 32'h1111_CC11;
    do_burst(1'b0, 32'h40, 1, 2'b00, 4'hF, "rd_0x40");
  endtask

  task automatic test_wrap4();
    clear_exp();
    rdata[0] = 32'h44; rdata[1] = 32'h11; rdata[2] = 32'h22; rdata[3] = 32'h33;
    do_burst(1'b0, 32'h10C, 4, 2'b01, 4'hF, "rd_wrap4");
  endtask

  task automatic test_out_of_range();
    clear_exp();
    wdata[0] = 32'h1234_5678;
    do_burst(1'b1, 32'h0, 1, 2'b00, 4'hF, "wr_word0");
    berr[0] = 1'b1;
    wdata[0] = 32'hDEAD_BEEF;
    do_burst(1'b1, 32'h400, 1, 2'b00, 4'hF, "wr_oor");
    clear_exp();
    rdata[0] = 32'h1234_5678;
    do_burst(1'b0, 32'h0, 1, 2'b00, 4'hF, "rd_word0");
    berr[0] = 1'b1;
    do_burst(1'b0, 32'h400, 1, 2'b00, 4'hF, "rd_oor");
    checks++;
    if (dat_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL oor_dat_hold: got %h, required %h", dat_o, 32'h1234_5678);
    end
    // Linear burst stepping from the last word into out-of-range space.
    clear_exp();
    wdata[0] = 32'hCAFE_F00D;
    do_burst(1'b1, 32'h3FC, 1, 2'b00, 4'hF, "wr_last");
    rdata[0] = 32'hCAFE_F00D;
    berr[1]  = 1'b1;
    do_burst(1'b0, 32'h3FC, 2, 2'b00, 4'hF, "rd_overrun");
  endtask

  // Classic access on the two-wait-state instance; ack must appear only in the third cycle.
  task automatic wait_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_d, input string name);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = 4'hF; cti = 3'b000; bte = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 4) stb = 1'b0;
      @(negedge clk);
      checks++;
      if (ack2 !== (c == 3) || err2 !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: ack=%b err=%b, required ack=%b err=0",
                 name, c, ack2, err2, (c == 3));
      end
      if (c == 3 && !w) begin
        checks++;
        if (dat2 !== exp_d) begin
          errors++;
          $display("FAIL %s data: got %h, required %h", name, dat2, exp_d);
        end
      end
    end
    end_cycle();
  endtask

  task automatic test_wait_states();
    end_cycle();
    wait_access(1'b1, 32'h80, 32'h5A5A_A5A5, 32'h0, "wait_wr");
    wait_access(1'b0, 32'h80, 32'h0, 32'h5A5A_A5A5, "wait_rd");
  endtask

  task automatic test_abort_cyc();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h100; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (ack !== 1'b1 || dat_o !== 32'h11 * (k + 1)) begin
        errors++;
        $display("FAIL abort_beat %0d: ack=%b dat=%h, required ack=1 dat=%h",
                 k, ack, dat_o, 32'h11 * (k + 1));
      end
    end
    checks++;
    if (bc !== 8'd2) begin
      errors++;
      $display("FAIL abort_cnt_before: got %0d, required 2", bc);
    end
    cyc = 1'b0; stb = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || err !== 1'b0 || bc !== 8'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle %0d: ack=%b err=%b cnt=%0d busy=%b, required 0 0 0 0",
                 c, ack, err, bc, busy);
      end
    end
    #1;
    clear_exp();
    rdata[0] = 32'h1111_CC11;
    do_burst(1'b0, 32'h40, 1, 2'b00, 4'hF, "rd_after_abort");
  endtask

  task automatic test_reset_mid_burst();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h100; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || dat_o !== 32'h22) begin
      errors++;
      $display("FAIL rst_pre: ack=%b dat=%h, required ack=1 dat=00000022", ack, dat_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dat_o !== '0 || ack !== 1'b0 || err !== 1'b0 || bc !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: dat=%h ack=%b err=%b cnt=%0d busy=%b, required all 0",
               dat_o, ack, err, bc, busy);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_exp();
    rdata[0] = 32'h22;
    do_burst(1'b0, 32'h104, 1, 2'b00, 4'hF, "rd_after_reset");
  endtask

  initial begin
    test_reset();
    test_burst_linear();
    test_byte_lanes();
    test_wrap4();
    test_out_of_range();
    test_wait_states();
    test_abort_cyc();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
